secded_post_ctrl: RTL and testbench

SECDED_POST_CTRL -- requirements
Module: secded_post_ctrl

---
 rtl/secded_pkg.sv | 19 +
 rtl/secded_fifo2.sv | 49 ++++
 rtl/secded_post_ctrl.sv | 136 +++++++++++++
 tb/tb_secded_post_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared defaults, FIFO entry layout and scrub FSM states for the SECDED post-decode controller.
package secded_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned SYN_W_DEF  = 6;
  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  poison;
  } fifo_entry_t;

  typedef enum logic {
    SCRUB_IDLE = 1'b0,
    SCRUB_REQ  = 1'b1
  } scrub_state_e;

endpackage

// File: rtl/secded_fifo2.sv
// Two-entry valid/ready FIFO; head and status come straight from registers.
module secded_fifo2
  import secded_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  fifo_entry_t push_entry_i,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        pop_i,
  output fifo_entry_t head_o
);

  logic [1:0]  cnt_q;
  logic        wr_q;
  logic        rd_q;
  fifo_entry_t mem_q [2];
  logic        do_push;
  logic        do_pop;

  assign ready_o = (cnt_q != 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && valid_o;
  // A push into a full FIFO is legal only alongside a pop (slot frees this cycle).
  assign do_push = push_i && (ready_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_entry_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/secded_post_ctrl.sv
// SECDED post-decode controller: buffering, error counters, DED interrupt and
// optional scrub write-back (enabled by defining SECDED_SCRUB_EN).
module secded_post_ctrl
  import secded_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SYN_W  = SYN_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [SYN_W-1:0]  in_syn,
  input  logic              in_sec,
  input  logic              in_ded,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_poison,
  output logic              scrub_req,
  input  logic              scrub_ack,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic [DATA_W-1:0] scrub_data,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  input  logic              cnt_clr,
  output logic              irq_ded
);

  logic             fifo_ready;
  logic             scrub_idle;
  logic             accept;
  logic             sec_inc;
  logic             ded_inc;
  fifo_entry_t      push_entry;
  fifo_entry_t      head;
  logic [CNT_W-1:0] sec_q;
  logic [CNT_W-1:0] ded_q;
  logic             irq_q;
  logic             unused_syn;

  assign unused_syn = ^in_syn;

  assign in_ready = ~rst & fifo_ready & scrub_idle;
  assign accept   = in_valid & in_ready;
  assign ded_inc  = accept & in_ded;
  assign sec_inc  = accept & in_sec & ~in_ded;

  assign push_entry.data   = in_data;
  assign push_entry.poison = in_ded;

  secded_fifo2 u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .ready_o      (fifo_ready),
    .valid_o      (out_valid),
    .pop_i        (out_ready),
    .head_o       (head)
  );

  assign out_data   = head.data;
  assign out_poison = head.poison;

  // Clear has priority over the old value but not over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q <= '0;
      ded_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (cnt_clr)                  sec_q <= sec_inc ? CNT_W'(1) : '0;
      else if (sec_inc && ~&sec_q)  sec_q <= sec_q + CNT_W'(1);
      if (cnt_clr)                  ded_q <= ded_inc ? CNT_W'(1) : '0;
      else if (ded_inc && ~&ded_q)  ded_q <= ded_q + CNT_W'(1);
      if (ded_inc)                  irq_q <= 1'b1;
      else if (cnt_clr)             irq_q <= 1'b0;
    end
  end

  assign sec_cnt = sec_q;
  assign ded_cnt = ded_q;
  assign irq_ded = irq_q;

`ifdef SECDED_SCRUB_EN
  scrub_state_e      state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCRUB_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        SCRUB_IDLE: if (sec_inc) begin
          state_q <= SCRUB_REQ;
          req_q   <= 1'b1;
          addr_q  <= in_addr;
          data_q  <= in_data;
        end
        SCRUB_REQ: if (scrub_ack) begin
          state_q <= SCRUB_IDLE;
          req_q   <= 1'b0;
        end
        default: begin
          state_q <= SCRUB_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign scrub_idle = (state_q == SCRUB_IDLE);
  assign scrub_req  = req_q;
  assign scrub_addr = addr_q;
  assign scrub_data = data_q;
`else
  logic unused_scrub;

  assign unused_scrub = scrub_ack ^ (^in_addr);
  assign scrub_idle   = 1'b1;
  assign scrub_req    = 1'b0;
  assign scrub_addr   = '0;
  assign scrub_data   = '0;
`endif

endmodule

// File: tb/tb_secded_post_ctrl.sv
// Self-checking bench for secded_post_ctrl against a queue-based reference model.
module tb_secded_post_ctrl;

  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [9:0]  in_addr = '0;
  logic [5:0]  in_syn = '0;
  logic        in_sec = 1'b0;
  logic        in_ded = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_poison;
  logic        scrub_req;
  logic        scrub_ack = 1'b0;
  logic [9:0]  scrub_addr;
  logic [15:0] scrub_data;
  logic [7:0]  sec_cnt;
  logic [7:0]  ded_cnt;
  logic        cnt_clr = 1'b0;
  logic        irq_ded;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [16:0] mq[$];
  int          m_sec = 0;
  int          m_ded = 0;
  bit          m_irq = 0;
  bit          m_req = 0;
  logic [9:0]  m_addr = '0;
  logic [15:0] m_data = '0;

  always #5 clk = ~clk;

  secded_post_ctrl #(.DATA_W(16), .SYN_W(6), .ADDR_W(10), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .in_syn     (in_syn),
    .in_sec     (in_sec),
    .in_ded     (in_ded),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_poison (out_poison),
    .scrub_req  (scrub_req),
    .scrub_ack  (scrub_ack),
    .scrub_addr (scrub_addr),
    .scrub_data (scrub_data),
    .sec_cnt    (sec_cnt),
    .ded_cnt    (ded_cnt),
    .cnt_clr    (cnt_clr),
    .irq_ded    (irq_ded)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return !rst && (mq.size() < 2) && !m_req;
  endfunction

  task automatic check_all();
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("out_data", {16'd0, out_data}, {16'd0, mq[0][15:0]});
      chk("out_poison", {31'd0, out_poison}, {31'd0, mq[0][16]});
    end
    chk("sec_cnt", {24'd0, sec_cnt}, m_sec);
    chk("ded_cnt", {24'd0, ded_cnt}, m_ded);
    chk("irq_ded", {31'd0, irq_ded}, {31'd0, m_irq});
    chk("scrub_req", {31'd0, scrub_req}, {31'd0, m_req});
`ifdef SECDED_SCRUB_EN
    if (m_req) begin
      chk("scrub_addr", {22'd0, scrub_addr}, {22'd0, m_addr});
      chk("scrub_data", {16'd0, scrub_data}, {16'd0, m_data});
    end
`else
    chk("scrub_addr0", {22'd0, scrub_addr}, 32'd0);
    chk("scrub_data0", {16'd0, scrub_data}, 32'd0);
`endif
  endtask

  // One clock: model consumes pre-edge inputs, outputs checked 1 time unit after the edge.
  task automatic step();
    bit acc, pop, sec, ded;
    acc = in_valid && m_ready();
    pop = (mq.size() > 0) && out_ready;
    ded = acc && in_ded;
    sec = acc && in_sec && !in_ded;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_sec = 0; m_ded = 0; m_irq = 0; m_req = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back({in_ded, in_data});
      if (cnt_clr) m_sec = sec ? 1 : 0;
      else if (sec && m_sec < CNT_MAX) m_sec++;
      if (cnt_clr) m_ded = ded ? 1 : 0;
      else if (ded && m_ded < CNT_MAX) m_ded++;
      if (ded) m_irq = 1;
      else if (cnt_clr) m_irq = 0;
`ifdef SECDED_SCRUB_EN
      if (m_req) begin
        if (scrub_ack) m_req = 0;
      end else if (sec) begin
        m_req = 1; m_addr = in_addr; m_data = in_data;
      end
`endif
    end
    check_all();
  endtask

  task automatic offer(input logic [15:0] d, input logic [9:0] a, input logic s, input logic e);
    in_valid = 1'b1; in_data = d; in_addr = a; in_sec = s; in_ded = e;
    in_syn = 6'($urandom);
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_sec = 1'b0; in_ded = 1'b0;
  endtask

  initial begin
    // Reset and reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_poison", {31'd0, out_poison}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #0;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // One clean word
    out_ready = 1'b0;
    offer(16'hA5A5, 10'h001, 1'b0, 1'b0);
    step();
    idle_in();
    chk("clean_valid", {31'd0, out_valid}, 32'd1);
    chk("clean_data", {16'd0, out_data}, 32'h0000A5A5);
    out_ready = 1'b1;
    step();

    // Back-pressure: three offers, two accepted, order preserved
    out_ready = 1'b0;
    offer(16'h1111, 10'h010, 1'b0, 1'b0); step();
    offer(16'h2222, 10'h011, 1'b0, 1'b0); step();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    offer(16'h3333, 10'h012, 1'b0, 1'b0); step();
    idle_in();
    out_ready = 1'b1;
    chk("drain_head0", {16'd0, out_data}, 32'h00001111);
    step();
    chk("drain_head1", {16'd0, out_data}, 32'h00002222);
    step();
    step();

    // SEC and DED together classify as DED
    offer(16'hBEEF, 10'h020, 1'b1, 1'b1);
    step();
    idle_in();
    chk("ded_cnt1", {24'd0, ded_cnt}, 32'd1);
    chk("ded_sec0", {24'd0, sec_cnt}, 32'd0);
    chk("ded_irq", {31'd0, irq_ded}, 32'd1);
    chk("ded_poison", {31'd0, out_poison}, 32'd1);
    chk("ded_noscrub", {31'd0, scrub_req}, 32'd0);
    step();

`ifdef SECDED_SCRUB_EN
    // Scrub request holds until acknowledged, blocking input meanwhile
    scrub_ack = 1'b0;
    offer(16'h1234, 10'h05A, 1'b1, 1'b0);
    step();
    offer(16'h5555, 10'h033, 1'b0, 1'b0);
    chk("scrub_req1", {31'd0, scrub_req}, 32'd1);
    chk("scrub_addr", {22'd0, scrub_addr}, 32'h05A);
    chk("scrub_data", {16'd0, scrub_data}, 32'h1234);
    chk("scrub_sec1", {24'd0, sec_cnt}, 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("scrub_block", {31'd0, in_ready}, 32'd0);
    idle_in();
    scrub_ack = 1'b1;
    step();
    scrub_ack = 1'b0;
    chk("scrub_done", {31'd0, scrub_req}, 32'd0);
    step();
`endif

    // Saturation then clear-with-increment
    out_ready = 1'b1;
    scrub_ack = 1'b1;
    for (int i = 0; i < 700; i++) begin
      offer(16'($urandom), 10'($urandom), 1'b1, 1'b0);
      step();
    end
    idle_in();
    chk("sec_sat", {24'd0, sec_cnt}, 32'd255);
    for (int i = 0; i < 4 && !m_ready(); i++) step();
    offer(16'h0F0F, 10'h0AA, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    idle_in();
    chk("clr_sec1", {24'd0, sec_cnt}, 32'd1);
    chk("clr_ded0", {24'd0, ded_cnt}, 32'd0);
    chk("clr_irq0", {31'd0, irq_ded}, 32'd0);
    step();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 16'($urandom);
      in_addr   = 10'($urandom);
      in_syn    = 6'($urandom);
      in_sec    = ($urandom_range(0, 3) == 0);
      in_ded    = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      scrub_ack = 1'($urandom);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      step();
    end
    idle_in();
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    scrub_ack = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Reset mid-operation with two words buffered
    out_ready = 1'b0;
    scrub_ack = 1'b0;
    offer(16'h7777, 10'h044, 1'b0, 1'b0); step();
    offer(16'h8888, 10'h045, 1'b1, 1'b0); step();
    idle_in();
    chk("mid_two_buf", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_req", {31'd0, scrub_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sec", {24'd0, sec_cnt}, 32'd0);
    chk("mid_rst_ded", {24'd0, ded_cnt}, 32'd0);
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
